// File: rtl/riscv_core_pkg.sv
// Shared types and constants for the RISC-V core front end.
package riscv_core_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] INST_NOP         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;

    // One buffered fetch result: the instruction word and the PC it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetchEntry_t;

    function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pc);
        return pc & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus bundle: control from the core, the instruction-memory
// channel and the decode-side instruction stream.
interface ifetch_unit_if;
    import riscv_core_pkg::*;

    logic            fetch_en;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;

    logic            inst_valid;
    logic            inst_ready;
    logic [ILEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;

    modport master (
        input  fetch_en, redirect_valid, redirect_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_ready,
        output imem_req_valid, imem_req_addr,
        output inst_valid, inst_data, inst_pc
    );

    modport slave (
        output fetch_en, redirect_valid, redirect_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_ready,
        input  imem_req_valid, imem_req_addr,
        input  inst_valid, inst_data, inst_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, inst} pairs between memory and decode.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       pushData,
    input  logic                   pop,
    output logic [WIDTH-1:0]       headData,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      cnt;
    logic             doPush;
    logic             doPop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == DEPTH_W);
    assign count    = cnt;
    assign headData = mem[rdPtr];

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (doPush && !flush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            cnt <= cnt + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end

    overflowCheck: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && full && !pop));

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: sequential PC, credit-limited imem requests, stale-response
// kill counter after redirects, and the instruction buffer toward decode.
module ifetch_unit
    import riscv_core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input logic           clk,
    input logic           rst_n,
    ifetch_unit_if.master bus
);

    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    logic [XLEN-1:0] fetchPc;
    logic [XLEN-1:0] rspPc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflightNext;
    logic [CW-1:0]   kill;
    logic [CW-1:0]   fifoCount;
    logic            creditOk;
    logic            reqValid;
    logic            reqFire;
    logic            rspKeep;
    logic            fifoPop;
    logic            fifoFull;
    logic            fifoEmpty;
    fetchEntry_t     pushEntry;
    fetchEntry_t     headEntry;

    // Requests in flight plus buffered entries never exceed the buffer size,
    // so every response is guaranteed a slot without backpressure.
    assign creditOk = ({1'b0, inflight} + {1'b0, fifoCount}) < DEPTH_W;
    assign reqValid = rst_n && bus.fetch_en && creditOk && !bus.redirect_valid;
    assign reqFire  = reqValid && bus.imem_req_ready;

    assign bus.imem_req_valid = reqValid;
    assign bus.imem_req_addr  = fetchPc;

    assign inflightNext = inflight + CW'(reqFire) - CW'(bus.imem_rsp_valid);

    // A response landing in a redirect cycle belongs to the old stream.
    assign rspKeep = bus.imem_rsp_valid && (kill == '0) && !bus.redirect_valid;
    assign fifoPop = !fifoEmpty && bus.inst_ready;

    assign pushEntry.pc   = rspPc;
    assign pushEntry.inst = bus.imem_rsp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchPc  <= RESET_PC;
            rspPc    <= RESET_PC;
            inflight <= '0;
            kill     <= '0;
        end else begin
            inflight <= inflightNext;
            if (bus.redirect_valid) begin
                fetchPc <= alignPc(bus.redirect_pc);
                rspPc   <= alignPc(bus.redirect_pc);
                kill    <= inflightNext;
            end else begin
                if (reqFire) begin
                    fetchPc <= fetchPc + PC_INC;
                end
                if (rspKeep) begin
                    rspPc <= rspPc + PC_INC;
                end
                if (bus.imem_rsp_valid && (kill != '0)) begin
                    kill <= kill - CW'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN + ILEN)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (bus.redirect_valid),
        .push     (rspKeep),
        .pushData (pushEntry),
        .pop      (fifoPop),
        .headData (headEntry),
        .count    (fifoCount),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    assign bus.inst_valid = !fifoEmpty;
    assign bus.inst_data  = headEntry.inst;
    assign bus.inst_pc    = headEntry.pc;

    killBound: assert property (@(posedge clk) disable iff (!rst_n)
        kill <= inflight);
    noStrayResponse: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.imem_rsp_valid && inflight == '0));
    noPushWhenFull: assert property (@(posedge clk) disable iff (!rst_n)
        !(rspKeep && fifoFull && !fifoPop));

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with an in-order variable-latency memory
// and a queue-level model of the expected instruction stream.
module tb_ifetch_unit;
    import riscv_core_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifetch_unit_if bus();

    ifetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } memReq_t;

    memReq_t     memQ[$];
    logic [63:0] outQ[$];
    logic [31:0] hsLog[$];
    logic [31:0] popLog[$];
    logic [31:0] mFetchPc;
    int          cyc;
    int          latency;
    int          lastDue;
    int          firstValidCyc;
    bit          sawCoincide;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] memFn(input logic [31:0] a);
        return (a * 32'd7) ^ 32'hC001_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: present memory response, check request side, clock,
    // advance the model, then check the decode side.
    task automatic tick();
        bit      rspV;
        bit      hs;
        bit      pop;
        bit      redir;
        int      due;
        memReq_t r;
        rspV = (memQ.size() > 0) && (memQ[0].due <= cyc);
        r = rspV ? memQ[0] : '{32'h0, 0, 1'b0};
        bus.imem_rsp_valid = rspV;
        bus.imem_rsp_data  = rspV ? memFn(r.addr) : 32'hDEAD_BEEF;
        #1;
        redir = bus.redirect_valid;
        check("req_valid", 64'(bus.imem_req_valid),
              64'(bus.fetch_en && !redir && (memQ.size() + outQ.size() < DEPTH)));
        hs = bus.imem_req_valid && bus.imem_req_ready;
        if (hs) begin
            check("req_addr", 64'(bus.imem_req_addr), 64'(mFetchPc));
            hsLog.push_back(bus.imem_req_addr);
        end
        pop = bus.inst_valid && bus.inst_ready && !redir;
        if (pop) popLog.push_back(bus.inst_pc);
        if (rspV && bus.inst_valid && redir) sawCoincide = 1'b1;
        @(posedge clk);
        if (rspV) void'(memQ.pop_front());
        if (pop) void'(outQ.pop_front());
        if (rspV && !r.stale && !redir) outQ.push_back({r.addr, memFn(r.addr)});
        if (redir) begin
            outQ.delete();
            foreach (memQ[i]) memQ[i].stale = 1'b1;
            mFetchPc = bus.redirect_pc & ~32'h3;
        end else if (hs) begin
            due = cyc + latency;
            if (due <= lastDue) due = lastDue + 1;
            memQ.push_back('{mFetchPc, due, 1'b0});
            lastDue = due;
            mFetchPc = mFetchPc + 32'd4;
        end
        cyc++;
        @(negedge clk);
        check("inst_valid", 64'(bus.inst_valid), 64'(outQ.size() > 0));
        if (outQ.size() > 0) begin
            check("inst_pc", 64'(bus.inst_pc), 64'(outQ[0][63:32]));
            check("inst_data", 64'(bus.inst_data), 64'(outQ[0][31:0]));
        end
        check("fetch_addr", 64'(bus.imem_req_addr), 64'(mFetchPc));
        if (firstValidCyc < 0 && bus.inst_valid) firstValidCyc = cyc;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.redirect_valid = 1'b0;
        #1;
        check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
        check("rst_req_addr", 64'(bus.imem_req_addr), 64'h0);
        check("rst_inst_data", 64'(bus.inst_data), 64'h0);
        check("rst_inst_pc", 64'(bus.inst_pc), 64'h0);
        memQ.delete();
        outQ.delete();
        hsLog.delete();
        popLog.delete();
        mFetchPc = 32'h0;
        cyc = 0;
        lastDue = -100;
        firstValidCyc = -1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic runUntilPops(input int n, input string name);
        int k;
        k = 0;
        while (popLog.size() < n && k < 40) begin
            tick();
            k++;
        end
        check(name, 64'(popLog.size() >= n), 64'd1);
    endtask

    initial begin
        bus.fetch_en       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.inst_ready     = 1'b1;
        latency            = 1;
        doReset();

        // Streaming with latency 1
        repeat (12) tick();
        check("t1_first_valid_cycle", 64'(firstValidCyc), 64'd2);
        check("t1_hs0", 64'(hsLog[0]), 64'h0);
        check("t1_hs1", 64'(hsLog[1]), 64'h4);
        check("t1_hs2", 64'(hsLog[2]), 64'h8);
        check("t1_pop0", 64'(popLog[0]), 64'h0);
        check("t1_pop1", 64'(popLog[1]), 64'h4);
        check("t1_pop2", 64'(popLog[2]), 64'h8);

        // Decode stalled: credit caps requests at two
        bus.inst_ready = 1'b0;
        doReset();
        repeat (10) tick();
        check("t2_hs_count", 64'(hsLog.size()), 64'd2);
        check("t2_hs1", 64'(hsLog[1]), 64'h4);
        check("t2_req_blocked", 64'(bus.imem_req_valid), 64'd0);
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        check("t2_req_after_pop", 64'(bus.imem_req_valid), 64'd1);
        check("t2_addr_after_pop", 64'(bus.imem_req_addr), 64'h8);

        // Redirect with two requests in flight
        latency = 3;
        doReset();
        tick();
        tick();
        check("t3_two_inflight", 64'(hsLog.size()), 64'd2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        tick();
        bus.redirect_valid = 1'b0;
        check("t3_empty_after_redirect", 64'(bus.inst_valid), 64'd0);
        bus.inst_ready = 1'b1;
        runUntilPops(1, "t3_pop_timeout");
        check("t3_first_new_req", 64'(hsLog[2]), 64'h100);
        check("t3_first_pc", 64'(popLog[0]), 64'h100);

        // Redirect coincident with a response and a pop
        latency = 1;
        doReset();
        tick();
        tick();
        sawCoincide = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        tick();
        bus.redirect_valid = 1'b0;
        check("t4_coincident", 64'(sawCoincide), 64'd1);
        runUntilPops(2, "t4_pop_timeout");
        check("t4_first_pc", 64'(popLog[0]), 64'h200);
        check("t4_second_pc", 64'(popLog[1]), 64'h204);

        // Unaligned redirect target and address wrap
        hsLog.delete();
        popLog.delete();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        tick();
        bus.redirect_valid = 1'b0;
        runUntilPops(2, "t5_pop_timeout");
        check("t5_hs0", 64'(hsLog[0]), 64'hFFFF_FFFC);
        check("t5_hs1", 64'(hsLog[1]), 64'h0);
        check("t5_pop0", 64'(popLog[0]), 64'hFFFF_FFFC);
        check("t5_pop1", 64'(popLog[1]), 64'h0);

        // Mixed backpressure, latency 2, fetch_en gaps
        latency = 2;
        for (int i = 0; i < 24; i++) begin
            bus.imem_req_ready = (i % 3) != 0;
            bus.inst_ready     = (i % 2) == 0;
            bus.fetch_en       = !(i >= 10 && i < 15);
            tick();
        end
        bus.imem_req_ready = 1'b1;
        bus.fetch_en       = 1'b1;

        // Asynchronous reset with the buffer full
        latency = 1;
        bus.inst_ready = 1'b0;
        repeat (8) tick();
        check("t7_full_valid", 64'(bus.inst_valid), 64'd1);
        #2;
        doReset();
        bus.inst_ready = 1'b1;
        runUntilPops(1, "t7_pop_timeout");
        check("t7_restart_addr", 64'(hsLog[0]), 64'h0);
        check("t7_restart_pc", 64'(popLog[0]), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
